// File: rtl/shared_buffer_pkg.sv
// shared_buffer_pkg: common state encoding and defaults for the shared-buffer FIFO blocks
package shared_buffer_pkg;
  localparam int DEFAULT_DATA_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: two-entry skid buffer turning a valid/ready stream into FIFO write strobes
module fifo_wr_skid
  import shared_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [1:0]            level
);
  state_t                state;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_xfer;
  logic                  out_xfer;
  assign in_xfer    = s_valid && s_ready;
  assign fifo_wr_en = (state != ST_EMPTY) && !fifo_full;
  assign out_xfer   = fifo_wr_en;
  assign fifo_din   = out_data;
  assign level      = state;
  // FSM: out_data is the head word, skid_data catches the word arriving while the FIFO stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      s_ready   <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          s_ready <= 1'b1;
          if (in_xfer) begin
            state    <= ST_ONE;
            out_data <= s_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            state     <= ST_TWO;
            skid_data <= s_data;
            s_ready   <= 1'b0;
          end else if (in_xfer) begin
            out_data <= s_data;
          end else if (out_xfer) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state    <= ST_ONE;
            out_data <= skid_data;
            s_ready  <= 1'b1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          s_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
